alert_handler_ping_reseed: RTL

Reseed controller directly upstream of the alert handler ping timer. It periodically fetches fresh entropy from the EDN via a req/ack handshake and assembles one or more EDN words into an LFSR-wide seed. It then presents that seed to the ping timer's tandem LFSRs with a single-cycle reseed strobe, replacing the tied-off reseed path (edn_req_o=0, reseed_en=0) in the ping timer.

---
 rtl/alert_handler_ping_reseed.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alert_handler_ping_reseed.sv
// alert_handler_ping_reseed: fetches entropy from the EDN, assembles an
// LFSR-wide seed and hands it to the ping timer with a one-cycle strobe.

package alert_handler_ping_reseed_pkg;
    // Every pair of codes differs in at least three bits, so a single upset
    // cannot turn one legal state into another.
    typedef enum logic [5:0] {
        IdleSt   = 6'b000111,
        ReqSt    = 6'b011010,
        ReseedSt = 6'b101100,
        CountSt  = 6'b110001,
        ErrSt    = 6'b111111
    } state_e;
endpackage

module alert_handler_ping_reseed
    import alert_handler_ping_reseed_pkg::*;
#(
    parameter int LfsrWidth   = 32,
    parameter int EdnDw       = 16,
    parameter int ReseedCntDw = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   force_reseed_i,
    input  logic [ReseedCntDw-1:0] reseed_period_i,
    output logic                   edn_req_o,
    input  logic                   edn_ack_i,
    input  logic [EdnDw-1:0]       edn_data_i,
    output logic                   reseed_en_o,
    output logic [LfsrWidth-1:0]   entropy_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int NumWords = LfsrWidth / EdnDw;
    localparam int IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

    state_e                 state;
    logic [IdxW-1:0]        idx;
    logic [ReseedCntDw-1:0] counter;
    logic [LfsrWidth-1:0]   shadow;
    logic [LfsrWidth-1:0]   shadow_next;

    // Shadow contents as they will be once the current EDN word is written.
    always_comb begin
        // NOTE: assign a default first so no path leaves shadow_next unassigned (no latch).
        shadow_next = shadow;
        shadow_next[idx*EdnDw +: EdnDw] = edn_data_i;
    end

    // Reseed FSM with registered outputs; the final ack loads entropy_o directly
    // so the seed and its strobe appear together one cycle after that ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IdleSt;
            idx         <= '0;
            counter     <= '0;
            // NOTE: the shadow is reset too, so a transfer cut short by reset
            // can never leak a stale word into a later seed.
            shadow      <= '0;
            edn_req_o   <= 1'b0;
            reseed_en_o <= 1'b0;
            entropy_o   <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge values of edn_req_o, counter and idx.
            if (edn_ack_i && !edn_req_o) begin
                err_o <= 1'b1;
            end

            case (state)
                IdleSt: begin
                    if (en_i) begin
                        state     <= ReqSt;
                        edn_req_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end

                ReqSt: begin
                    if (edn_ack_i) begin
                        shadow <= shadow_next;
                        if (idx == LastIdx) begin
                            idx         <= '0;
                            entropy_o   <= shadow_next;
                            reseed_en_o <= 1'b1;
                            edn_req_o   <= 1'b0;
                            state       <= ReseedSt;
                        end else begin
                            idx <= idx + IdxW'(1);
                        end
                    end
                end

                ReseedSt: begin
                    reseed_en_o <= 1'b0;
                    busy_o      <= 1'b0;
                    counter     <= '0;
                    state       <= CountSt;
                end

                CountSt: begin
                    if (counter != '1) begin
                        counter <= counter + ReseedCntDw'(1);
                    end
                    if ((counter >= reseed_period_i) || force_reseed_i) begin
                        state     <= ReqSt;
                        edn_req_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end

                // ErrSt and every illegal encoding land here and stay until reset.
                default: begin
                    state       <= ErrSt;
                    edn_req_o   <= 1'b0;
                    reseed_en_o <= 1'b0;
                    busy_o      <= 1'b0;
                    err_o       <= 1'b1;
                end
            endcase
        end
    end

endmodule
